// File: rtl/digit_sequencer.sv
// BCD digit source for the matrix driver: debounced inc/dec/mode buttons, MANUAL/AUTO FSM, blink.
// Latency: press pulse 2+DEBOUNCE_CYCLES cycles after a clean edge, digit one cycle later; no backpressure.
module digit_sequencer #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int AUTO_PERIOD     = 1000,
  parameter int BLINK_HALF      = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_mode,
  input  logic       display_en,
  output logic [3:0] digit,
  output logic       display_active,
  output logic       auto_mode,
  output logic       wrap
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(AUTO_PERIOD);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(AUTO_PERIOD - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

  // Button lanes: bit 0 = inc, bit 1 = dec, bit 2 = mode
  logic [2:0]    btn_raw, sync1, sync2, level, press;
  logic [DW-1:0] db_cnt [3];

  assign btn_raw = {btn_mode, btn_dec, btn_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          // Accept the new level; only a rising acceptance counts as a press
          db_cnt[i] <= '0;
          level[i]  <= ~level[i];
          press[i]  <= ~level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic inc_p, dec_p, mode_p;
  assign inc_p  = press[0];
  assign dec_p  = press[1];
  assign mode_p = press[2];

  state_t        state, state_nxt;
  logic [3:0]    digit_nxt;
  logic          wrap_nxt, dir_up, dir_nxt, blink_phase, phase_nxt;
  logic          step_up, step_dn;
  logic [PW-1:0] prescaler, pre_nxt;
  logic [BW-1:0] blink_cnt, blink_nxt;

  assign auto_mode = (state == AUTO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= MANUAL;
      digit          <= 4'd0;
      wrap           <= 1'b0;
      dir_up         <= 1'b1;
      prescaler      <= '0;
      blink_cnt      <= '0;
      blink_phase    <= 1'b1;
      display_active <= 1'b1;
    end else begin
      state          <= state_nxt;
      digit          <= digit_nxt;
      wrap           <= wrap_nxt;
      dir_up         <= dir_nxt;
      prescaler      <= pre_nxt;
      blink_cnt      <= blink_nxt;
      blink_phase    <= phase_nxt;
      display_active <= display_en & (auto_mode | blink_phase);
    end
  end

  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    wrap_nxt  = 1'b0;
    dir_nxt   = dir_up;
    pre_nxt   = prescaler;
    blink_nxt = blink_cnt;
    phase_nxt = blink_phase;
    step_up   = 1'b0;
    step_dn   = 1'b0;

    case (state)
      MANUAL: begin
        if (blink_cnt == BLINK_LAST) begin
          blink_nxt = '0;
          phase_nxt = ~blink_phase;
        end else begin
          blink_nxt = blink_cnt + 1'b1;
        end
        // An edit restarts the blink so the new digit shows at once
        if (inc_p || dec_p) begin
          blink_nxt = '0;
          phase_nxt = 1'b1;
        end
        step_up = inc_p & ~dec_p;
        step_dn = dec_p & ~inc_p;
        if (mode_p) begin
          state_nxt = AUTO;
          pre_nxt   = '0;
        end
      end
      AUTO: begin
        if (inc_p && !dec_p) dir_nxt = 1'b1;
        if (dec_p && !inc_p) dir_nxt = 1'b0;
        if (prescaler == PRE_LAST) begin
          pre_nxt = '0;
          step_up = dir_up;
          step_dn = ~dir_up;
        end else begin
          pre_nxt = prescaler + 1'b1;
        end
        if (mode_p) begin
          state_nxt = MANUAL;
          blink_nxt = '0;
          phase_nxt = 1'b1;
        end
      end
      default: state_nxt = MANUAL;
    endcase

    if (step_up) begin
      if (digit >= 4'd9) begin
        digit_nxt = 4'd0;
        wrap_nxt  = 1'b1;
      end else begin
        digit_nxt = digit + 4'd1;
      end
    end else if (step_dn) begin
      if (digit == 4'd0 || digit > 4'd9) begin
        digit_nxt = 4'd9;
        wrap_nxt  = 1'b1;
      end else begin
        digit_nxt = digit - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_digit_sequencer.sv
// Directed bench for digit_sequencer: expected digit/wrap pushed at stimulus, popped at DUT update.
module tb_digit_sequencer;

  localparam int DB = 20;

  logic       clk;
  logic       rst, btn_inc, btn_dec, btn_mode, display_en;
  logic [3:0] digit;
  logic       display_active, auto_mode, wrap;

  int n_checks = 0;
  int n_errors = 0;
  bit da_ok;

  typedef struct {
    string      tag;
    logic [3:0] digit;
    logic       wrap;
  } exp_t;
  exp_t sb[$];

  digit_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .AUTO_PERIOD    (1000),
    .BLINK_HALF     (250)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_inc       (btn_inc),
    .btn_dec       (btn_dec),
    .btn_mode      (btn_mode),
    .display_en    (display_en),
    .digit         (digit),
    .display_active(display_active),
    .auto_mode     (auto_mode),
    .wrap          (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string tag, input int d, input bit w);
    exp_t e;
    e.tag   = tag;
    e.digit = 4'(d);
    e.wrap  = w;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL sb_underflow: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_digit"}, 32'(digit), 32'(e.digit));
      chk({e.tag, "_wrap"}, 32'(wrap), 32'(e.wrap));
    end
  endtask

  // Returns on the sample point after the edge where the debounced press lands
  task automatic hold_btns(input bit i, input bit d, input bit m);
    btn_inc  = i;
    btn_dec  = d;
    btn_mode = m;
    tick(DB + 3);
  endtask

  task automatic release_btns();
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    btn_mode = 1'b0;
    tick(DB + 5);
  endtask

  task automatic manual_press(input string tag, input bit i, input bit d, input int exp_d, input bit exp_w);
    push(tag, exp_d, exp_w);
    hold_btns(i, d, 1'b0);
    sb_check();
    tick(1);
    chk({tag, "_wrap_off"}, 32'(wrap), 32'd0);
    chk({tag, "_hold"}, 32'(digit), 32'(exp_d));
    release_btns();
  endtask

  initial begin
    int seq[7];
    seq = '{3, 2, 1, 0, 9, 8, 7};

    rst        = 1'b1;
    btn_inc    = 1'b0;
    btn_dec    = 1'b0;
    btn_mode   = 1'b0;
    display_en = 1'b1;
    tick(3);
    chk("rst_digit", 32'(digit), 32'd0);
    chk("rst_display_active", 32'(display_active), 32'd1);
    chk("rst_auto_mode", 32'(auto_mode), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    rst = 1'b0;
    tick(5);

    // Bouncing contact, then a clean hold: one step only
    for (int k = 0; k < 12; k++) begin
      btn_inc = (k % 2 == 0);
      tick(5);
    end
    chk("bounce_no_step", 32'(digit), 32'd0);
    btn_inc = 1'b1;
    push("bounce_step", 1, 1'b0);
    tick(DB + 2);
    chk("bounce_latency_early", 32'(digit), 32'd0);
    tick(1);
    sb_check();
    release_btns();

    push("glitch_ignored", 1, 1'b0);
    btn_inc = 1'b1;
    tick(15);
    btn_inc = 1'b0;
    tick(40);
    sb_check();

    for (int k = 2; k <= 9; k++) manual_press($sformatf("inc_to_%0d", k), 1'b1, 1'b0, k, 1'b0);
    manual_press("inc_wrap", 1'b1, 1'b0, 0, 1'b1);
    manual_press("dec_wrap", 1'b0, 1'b1, 9, 1'b1);
    manual_press("inc_dec_same", 1'b1, 1'b1, 9, 1'b0);
    manual_press("inc_wrap2", 1'b1, 1'b0, 0, 1'b1);
    for (int k = 1; k <= 3; k++) manual_press($sformatf("inc_up_%0d", k), 1'b1, 1'b0, k, 1'b0);

    // AUTO entry from 3
    push("auto_enter", 3, 1'b0);
    hold_btns(1'b0, 1'b0, 1'b1);
    sb_check();
    chk("auto_mode_on", 32'(auto_mode), 32'd1);
    btn_mode = 1'b0;
    push("auto_tick4", 4, 1'b0);
    da_ok = 1'b1;
    for (int k = 0; k < 999; k++) begin
      tick(1);
      if (display_active !== 1'b1) da_ok = 1'b0;
    end
    chk("auto_before_tick4", 32'(digit), 32'd3);
    tick(1);
    sb_check();
    chk("auto_display_steady", 32'(da_ok), 32'd1);

    push("auto_tick5", 5, 1'b0);
    tick(999);
    chk("auto_before_tick5", 32'(digit), 32'd4);
    tick(1);
    sb_check();

    // Direction change must not step or disturb the tick phase
    push("auto_dec_tick", 4, 1'b0);
    btn_dec = 1'b1;
    tick(DB + 3);
    chk("auto_dec_no_step", 32'(digit), 32'd5);
    chk("auto_dec_keeps_mode", 32'(auto_mode), 32'd1);
    btn_dec = 1'b0;
    tick(1000 - (DB + 3) - 1);
    chk("auto_dec_no_phase_jump", 32'(digit), 32'd5);
    tick(1);
    sb_check();

    for (int k = 0; k < 7; k++) begin
      push($sformatf("auto_down_%0d", seq[k]), seq[k], seq[k] == 9);
      tick(1000);
      sb_check();
    end

    display_en = 1'b0;
    tick(1);
    chk("en_off_auto", 32'(display_active), 32'd0);
    display_en = 1'b1;
    tick(1);
    chk("en_on_auto", 32'(display_active), 32'd1);

    // Asynchronous reset mid-AUTO, sampled before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("midrst_digit", 32'(digit), 32'd0);
    chk("midrst_auto_mode", 32'(auto_mode), 32'd0);
    chk("midrst_wrap", 32'(wrap), 32'd0);
    chk("midrst_display_active", 32'(display_active), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    tick(250);
    chk("blink_on_end", 32'(display_active), 32'd1);
    tick(1);
    chk("blink_off_start", 32'(display_active), 32'd0);
    tick(249);
    chk("blink_off_end", 32'(display_active), 32'd0);
    tick(1);
    chk("blink_on_again", 32'(display_active), 32'd1);

    display_en = 1'b0;
    tick(1);
    chk("en_off_manual", 32'(display_active), 32'd0);
    display_en = 1'b1;
    tick(1);
    chk("en_on_manual", 32'(display_active), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
